pp_block_buffer: RTL and testbench

Parametrised ping-pong block buffer for the WiMAX transmit chain. Sits between a streaming producer (randomizer / FEC encoder) and a random-access consumer (interleaver). The producer streams symbols with a valid/ready handshake and internal address generation. The consumer reads the completed block at arbitrary addresses and explicitly releases it. Two banks alternate, so a new block can be written while the previous one is read, with backpressure when both banks are occupied.

---
 rtl/pp_block_buffer.sv | 137 +++++++++++++
 tb/tb_pp_block_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_block_buffer.sv
// Ping-pong block buffer: streaming writer fills one bank while the consumer reads the other.
// Define PPB_ADDR_CHECK_EN to build the out-of-range read guard and the sticky err flag.
module pp_block_buffer #(
    parameter int DATA_W    = 1,
    parameter int BLOCK_LEN = 192,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              blk_avail,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              blk_release,
    output logic              err
);

    localparam int CNT_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

    logic [DATA_W-1:0] mem0 [BLOCK_LEN];
    logic [DATA_W-1:0] mem1 [BLOCK_LEN];

    // state bit per bank: 1 = FULL, 0 = EMPTY
    logic [1:0]        state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              accept;
    logic              rd_ok;
    logic              rel_ok;
    logic [CNT_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;

    assign in_ready  = ~state_q[wr_bank_q];
    assign blk_avail = state_q[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign rd_ok     = rd_en && blk_avail;
    assign rel_ok    = blk_release && blk_avail;
    assign rd_idx    = CNT_W'(rd_addr);
    assign rd_word   = rd_bank_q ? mem1[rd_idx] : mem0[rd_idx];

`ifdef PPB_ADDR_CHECK_EN
    logic err_q, err_d;
    logic addr_bad;
    assign addr_bad = (ADDR_W+1)'(rd_addr) >= (ADDR_W+1)'(BLOCK_LEN);
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_bank_d  = rd_bank_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_ok;
        if (accept) begin
            if (wr_cnt_q == LAST_IDX) begin
                state_d[wr_bank_q] = 1'b1;
                wr_cnt_d           = '0;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end
        // write bank is never FULL, so this never collides with the completion above
        if (rel_ok) begin
            state_d[rd_bank_q] = 1'b0;
            rd_bank_d          = ~rd_bank_q;
        end
        if (rd_ok) begin
            rd_data_d = rd_word;
        end
`ifdef PPB_ADDR_CHECK_EN
        err_d = err_q;
        if (rd_ok && addr_bad) begin
            rd_data_d = '0;
            err_d     = 1'b1;
        end
        if ((rd_en || blk_release) && !blk_avail) begin
            err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef PPB_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            if (wr_bank_q) begin
                mem1[wr_cnt_q] <= in_data;
            end else begin
                mem0[wr_cnt_q] <= in_data;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pp_block_buffer.sv
// Self-checking bench for pp_block_buffer: a FIFO-of-blocks reference model checked every cycle,
// plus directed checks for pattern load, streaming, backpressure, errors and mid-block reset.
module tb_pp_block_buffer;

    localparam int DATA_W    = 1;
    localparam int BLOCK_LEN = 192;
    localparam int ADDR_W    = 9;
    localparam int SLOTS     = 32;
`ifdef PPB_ADDR_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              blk_avail;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              blk_release = 1'b0;
    logic              err;

    pp_block_buffer #(.DATA_W(DATA_W), .BLOCK_LEN(BLOCK_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .blk_avail(blk_avail), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .blk_release(blk_release), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of completed blocks plus the block being filled.
    int                full_q[$];
    int                cur_slot = 0;
    int                wcount = 0;
    logic [DATA_W-1:0] store [SLOTS][BLOCK_LEN];
    logic              exp_rd_valid = 1'b0;
    logic [DATA_W-1:0] exp_rd_data = '0;
    bit                exp_data_known = 1'b1;
    logic              exp_err = 1'b0;
    int                total_acc = 0;
    int                total_done = 0;
    int                total_rel = 0;
    bit                last_acc = 1'b0;

    logic [191:0] pat = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model with the current inputs.
    task automatic applyStimulus();
        int nf;
        bit acc, rok, rel;
        @(negedge clk);
        checkOutput("in_ready", 32'(in_ready), 32'(full_q.size() < 2));
        checkOutput("blk_avail", 32'(blk_avail), 32'(full_q.size() > 0));
        checkOutput("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
        if (exp_data_known) checkOutput("rd_data", 32'(rd_data), 32'(exp_rd_data));
        checkOutput("err", 32'(err), 32'(exp_err));
        if (reset) begin
            full_q.delete();
            wcount         = 0;
            cur_slot       = (cur_slot + 1) % SLOTS;
            exp_rd_valid   = 1'b0;
            exp_rd_data    = '0;
            exp_data_known = 1'b1;
            exp_err        = 1'b0;
            last_acc       = 1'b0;
        end else begin
            nf  = full_q.size();
            acc = in_valid && (nf < 2);
            rok = rd_en && (nf > 0);
            rel = blk_release && (nf > 0);
            exp_rd_valid = rok;
            if (rok) begin
                if (int'(rd_addr) < BLOCK_LEN) begin
                    exp_rd_data    = store[full_q[0]][int'(rd_addr)];
                    exp_data_known = 1'b1;
                end else if (CHECK_EN) begin
                    exp_rd_data    = '0;
                    exp_data_known = 1'b1;
                    exp_err        = 1'b1;
                end else begin
                    exp_data_known = 1'b0;
                end
            end
            if (CHECK_EN && (rd_en || blk_release) && nf == 0) exp_err = 1'b1;
            if (rel) begin
                void'(full_q.pop_front());
                total_rel++;
            end
            if (acc) begin
                store[cur_slot][wcount] = in_data;
                wcount++;
                total_acc++;
                if (wcount == BLOCK_LEN) begin
                    full_q.push_back(cur_slot);
                    cur_slot = (cur_slot + 1) % SLOTS;
                    wcount   = 0;
                    total_done++;
                end
            end
            last_acc = acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic produce(input int n);
        int target = total_acc + n;
        int budget = 0;
        bit hold = 1'b0;
        while (total_acc < target && budget < n * 4 + 50) begin
            in_valid = 1'b1;
            if (!hold) in_data = DATA_W'($urandom);
            applyStimulus();
            hold = !last_acc;
            budget++;
        end
    endtask

    task automatic readBlock(input bit rel);
        for (int a = 0; a < BLOCK_LEN; a++) begin
            rd_en       = 1'b1;
            rd_addr     = ADDR_W'(a);
            blk_release = rel && (a == BLOCK_LEN - 1);
            applyStimulus();
        end
        rd_en       = 1'b0;
        blk_release = 1'b0;
    endtask

    task automatic streamBlocks(input int nblk);
        int target     = total_acc + nblk * BLOCK_LEN;
        int rel_target = total_rel + nblk;
        int first_done = total_done + 1;
        int rd_ptr     = 0;
        int stalls     = 0;
        int budget     = 0;
        while (total_rel < rel_target && budget < nblk * BLOCK_LEN + 1000) begin
            in_valid = (total_acc < target);
            in_data  = DATA_W'($urandom);
            if (full_q.size() > 0) begin
                rd_en       = 1'b1;
                rd_addr     = ADDR_W'(rd_ptr);
                blk_release = (rd_ptr == BLOCK_LEN - 1);
                rd_ptr      = (rd_ptr == BLOCK_LEN - 1) ? 0 : rd_ptr + 1;
            end else begin
                rd_en       = 1'b0;
                blk_release = 1'b0;
            end
            applyStimulus();
            if (total_done >= first_done && total_acc < target && in_ready !== 1'b1) stalls++;
            budget++;
        end
        in_valid    = 1'b0;
        rd_en       = 1'b0;
        blk_release = 1'b0;
        checkOutput("stream_stalls", 32'(stalls), 32'd0);
        checkOutput("stream_blocks", 32'(total_rel - rel_target + nblk), 32'(nblk));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] pattern block");
        for (int i = 0; i < BLOCK_LEN; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(pat[i]);
            applyStimulus();
            checkOutput("pattern_accept", 32'(last_acc), 32'd1);
        end
        in_valid = 1'b0;
        checkOutput("pattern_avail", 32'(blk_avail), 32'd1);
        for (int a = 0; a < BLOCK_LEN; a++) begin
            rd_en       = 1'b1;
            rd_addr     = ADDR_W'(a);
            blk_release = (a == BLOCK_LEN - 1);
            applyStimulus();
            checkOutput("pattern_rd", 32'(rd_data), 32'(pat[a]));
        end
        rd_en       = 1'b0;
        blk_release = 1'b0;
        applyStimulus();

        $display("[TB] streaming");
        streamBlocks(10);
        applyStimulus();

        $display("[TB] backpressure");
        produce(2 * BLOCK_LEN);
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
        repeat (5) applyStimulus();
        checkOutput("bp_stalled", 32'(in_ready), 32'd0);
        blk_release = 1'b1;
        applyStimulus();
        blk_release = 1'b0;
        checkOutput("bp_ready_after_release", 32'(in_ready), 32'd1);
        applyStimulus();
        produce(BLOCK_LEN - 1);
        in_valid = 1'b0;
        applyStimulus();
        readBlock(1'b1);
        readBlock(1'b1);
        applyStimulus();

        $display("[TB] protocol errors");
        blk_release = 1'b1;
        applyStimulus();
        blk_release = 1'b0;
        applyStimulus();
        checkOutput("err_release", 32'(err), 32'(CHECK_EN));
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("err_reset", 32'(err), 32'd0);
        produce(BLOCK_LEN);
        in_valid = 1'b0;
        rd_en    = 1'b1;
        rd_addr  = ADDR_W'(200);
        applyStimulus();
        rd_en = 1'b0;
        checkOutput("err_oob", 32'(err), 32'(CHECK_EN));
        checkOutput("oob_rd_valid", 32'(rd_valid), 32'd1);
`ifdef PPB_ADDR_CHECK_EN
        checkOutput("oob_rd_data", 32'(rd_data), 32'd0);
`endif
        readBlock(1'b1);

        $display("[TB] reset mid-block");
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        produce(100);
        in_valid = 1'b0;
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("mid_reset_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_reset_avail", 32'(blk_avail), 32'd0);
        produce(BLOCK_LEN);
        in_valid = 1'b0;
        checkOutput("mid_reset_block", 32'(blk_avail), 32'd1);
        readBlock(1'b1);

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom_range(99) < 70);
                in_data  = DATA_W'($urandom);
            end
            rd_en       = ($urandom_range(99) < 60);
            rd_addr     = ADDR_W'($urandom_range(BLOCK_LEN - 1));
            blk_release = ($urandom_range(99) < 3);
            applyStimulus();
        end
        in_valid    = 1'b0;
        rd_en       = 1'b0;
        blk_release = 1'b0;
        applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
